fft_stage_sequencer: RTL and testbench

//  Sequences an in-place radix-2 DIT FFT over the two ping-pong sample banks. Phase 0 (REORDER)

---
 rtl/fft_stage_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_fft_stage_sequencer.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_stage_sequencer.sv
// Address/enable sequencer for an in-place radix-2 DIT FFT over two ping-pong banks:
// a bit-reverse copy phase followed by LOG2N butterfly stages, with writes trailing reads by PIPE_LAT.
module fft_stage_sequencer #(
  parameter int N        = 8,
  parameter int LOG2N    = 3,
  parameter int PIPE_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [LOG2N-1:0] stage,
  output logic             rd_bank,
  output logic             rd_en_a,
  output logic             rd_en_b,
  output logic [LOG2N-1:0] rd_addr_a,
  output logic [LOG2N-1:0] rd_addr_b,
  output logic             wr_en_a,
  output logic             wr_en_b,
  output logic [LOG2N-1:0] wr_addr_a,
  output logic [LOG2N-1:0] wr_addr_b,
  output logic [LOG2N-2:0] tw_addr,
  output logic             out_bank
);

  localparam int PW   = $clog2(PIPE_LAT + 1);
  localparam int CW   = (LOG2N > PW) ? LOG2N : PW;
  localparam int TW_W = LOG2N - 1;
  localparam logic [CW-1:0]    REORD_LAST = CW'(N - 1);
  localparam logic [CW-1:0]    BFLY_LAST  = CW'(N / 2 - 1);
  localparam logic [CW-1:0]    DRAIN_LAST = CW'(PIPE_LAT - 1);
  localparam logic [LOG2N-1:0] LAST_STAGE = LOG2N'(LOG2N);

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, SWAP, FIN} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [LOG2N-1:0] stage_nxt;
  logic             rd_bank_nxt;
  logic             out_bank_nxt;

  logic [LOG2N-1:0] b, s, tw_sh, half, mask, bf_a, d_addr_a;

  logic             vld_a_p  [PIPE_LAT];
  logic             vld_b_p  [PIPE_LAT];
  logic [LOG2N-1:0] addr_a_p [PIPE_LAT];
  logic [LOG2N-1:0] addr_b_p [PIPE_LAT];

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] x);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = x[LOG2N-1-i];
    return r;
  endfunction

  // Butterfly pairing: insert a zero at bit s of the counter to get the lower index.
  always_comb begin
    b     = LOG2N'(cnt);
    s     = stage - LOG2N'(1);
    tw_sh = LOG2N'(LOG2N - 1) - s;
    half  = LOG2N'(1) << s;
    mask  = half - LOG2N'(1);
    bf_a  = ((b >> s) << stage) | (b & mask);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      stage    <= '0;
      rd_bank  <= 1'b0;
      out_bank <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      stage    <= stage_nxt;
      rd_bank  <= rd_bank_nxt;
      out_bank <= out_bank_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    stage_nxt    = stage;
    rd_bank_nxt  = rd_bank;
    out_bank_nxt = out_bank;
    busy         = 1'b0;
    done         = 1'b0;
    rd_en_a      = 1'b0;
    rd_en_b      = 1'b0;
    rd_addr_a    = '0;
    rd_addr_b    = '0;
    tw_addr      = '0;
    case (state)
      IDLE: begin
        if (start) begin
          stage_nxt   = '0;
          rd_bank_nxt = 1'b0;
          cnt_nxt     = '0;
          state_nxt   = ISSUE;
        end
      end
      ISSUE: begin
        busy    = 1'b1;
        rd_en_a = 1'b1;
        if (stage == '0) begin
          rd_addr_a = b;
        end else begin
          rd_en_b   = 1'b1;
          rd_addr_a = bf_a;
          rd_addr_b = bf_a + half;
          tw_addr   = TW_W'((b & mask) << tw_sh);
        end
        if (cnt == ((stage == '0) ? REORD_LAST : BFLY_LAST)) begin
          cnt_nxt   = '0;
          state_nxt = DRAIN;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (cnt == DRAIN_LAST) begin
          cnt_nxt   = '0;
          state_nxt = SWAP;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      SWAP: begin
        busy        = 1'b1;
        rd_bank_nxt = ~rd_bank;
        if (stage == LAST_STAGE) begin
          out_bank_nxt = ~rd_bank;
          state_nxt    = FIN;
        end else begin
          stage_nxt = stage + LOG2N'(1);
          cnt_nxt   = '0;
          state_nxt = ISSUE;
        end
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign d_addr_a = (stage == '0) ? bitrev(rd_addr_a) : rd_addr_a;

  // Write delay line: strobes are cleared on reset so aborted transforms never write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        vld_a_p[i] <= 1'b0;
        vld_b_p[i] <= 1'b0;
      end
    end else begin
      vld_a_p[0] <= rd_en_a;
      vld_b_p[0] <= rd_en_b;
      for (int i = 1; i < PIPE_LAT; i++) begin
        vld_a_p[i] <= vld_a_p[i-1];
        vld_b_p[i] <= vld_b_p[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    addr_a_p[0] <= d_addr_a;
    addr_b_p[0] <= rd_addr_b;
    for (int i = 1; i < PIPE_LAT; i++) begin
      addr_a_p[i] <= addr_a_p[i-1];
      addr_b_p[i] <= addr_b_p[i-1];
    end
  end

  assign wr_en_a   = vld_a_p[PIPE_LAT-1];
  assign wr_en_b   = vld_b_p[PIPE_LAT-1];
  assign wr_addr_a = wr_en_a ? addr_a_p[PIPE_LAT-1] : '0;
  assign wr_addr_b = wr_en_b ? addr_b_p[PIPE_LAT-1] : '0;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Bench for fft_stage_sequencer: two instances (N=8/PIPE_LAT=2 and N=16/PIPE_LAT=1) compared
// cycle by cycle against a schedule model derived from phase lengths and butterfly pairing rules.
module tb_fft_stage_sequencer;

  localparam int N8  = 8;
  localparam int L8  = 3;
  localparam int P8  = 2;
  localparam int N16 = 16;
  localparam int L16 = 4;
  localparam int P16 = 1;
  localparam int T8  = (N8 + P8 + 1) + L8 * (N8 / 2 + P8 + 1) + 1;
  localparam int T16 = (N16 + P16 + 1) + L16 * (N16 / 2 + P16 + 1) + 1;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [3:0] stage;
    logic       rd_bank;
    logic       rd_en_a;
    logic       rd_en_b;
    logic [3:0] rd_addr_a;
    logic [3:0] rd_addr_b;
    logic       wr_en_a;
    logic       wr_en_b;
    logic [3:0] wr_addr_a;
    logic [3:0] wr_addr_b;
    logic [3:0] tw;
    logic       out_bank;
  } cyc_t;

  logic clk, rst, start8, start16;
  int   n_cmp, n_bad;

  logic       busy8, done8, rd_bank8, rd_en_a8, rd_en_b8, wr_en_a8, wr_en_b8, out_bank8;
  logic [2:0] stage8, rd_addr_a8, rd_addr_b8, wr_addr_a8, wr_addr_b8;
  logic [1:0] tw8;

  logic       busy16, done16, rd_bank16, rd_en_a16, rd_en_b16, wr_en_a16, wr_en_b16, out_bank16;
  logic [3:0] stage16, rd_addr_a16, rd_addr_b16, wr_addr_a16, wr_addr_b16;
  logic [2:0] tw16;

  fft_stage_sequencer #(.N(N8), .LOG2N(L8), .PIPE_LAT(P8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .busy(busy8), .done(done8), .stage(stage8),
    .rd_bank(rd_bank8), .rd_en_a(rd_en_a8), .rd_en_b(rd_en_b8),
    .rd_addr_a(rd_addr_a8), .rd_addr_b(rd_addr_b8), .wr_en_a(wr_en_a8), .wr_en_b(wr_en_b8),
    .wr_addr_a(wr_addr_a8), .wr_addr_b(wr_addr_b8), .tw_addr(tw8), .out_bank(out_bank8)
  );

  fft_stage_sequencer #(.N(N16), .LOG2N(L16), .PIPE_LAT(P16)) u16 (
    .clk(clk), .rst(rst), .start(start16), .busy(busy16), .done(done16), .stage(stage16),
    .rd_bank(rd_bank16), .rd_en_a(rd_en_a16), .rd_en_b(rd_en_b16),
    .rd_addr_a(rd_addr_a16), .rd_addr_b(rd_addr_b16), .wr_en_a(wr_en_a16), .wr_en_b(wr_en_b16),
    .wr_addr_a(wr_addr_a16), .wr_addr_b(wr_addr_b16), .tw_addr(tw16), .out_bank(out_bank16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int bitrev_m(int x, int lg);
    int r, v;
    r = 0;
    v = x;
    for (int i = 0; i < lg; i++) begin
      r = r * 2 + v % 2;
      v = v / 2;
    end
    return r;
  endfunction

  // r-th index (ascending) whose bit for this stage is clear, i.e. the lower member of pair r.
  function automatic int pair_lo(int n, int half, int r);
    int c, res;
    c = 0;
    res = 0;
    for (int i = 0; i < n; i++) begin
      if ((i / half) % 2 == 0) begin
        if (c == r) res = i;
        c++;
      end
    end
    return res;
  endfunction

  // Expected outputs in cycle k after the start-accept edge (k > T means back in IDLE).
  function automatic cyc_t model(int n, int lg, int pl, int k, logic ob_prev);
    cyc_t e;
    int t, len0, lens, ph, off, niss, half, i, r;
    e = '0;
    t = (n + pl + 1) + lg * (n / 2 + pl + 1) + 1;
    len0 = n + pl + 1;
    lens = n / 2 + pl + 1;
    e.out_bank = ob_prev;
    if (k >= t) begin
      e.done     = (k == t);
      e.stage    = 4'(lg);
      e.rd_bank  = 1'((lg + 1) % 2);
      e.out_bank = 1'((lg + 1) % 2);
      return e;
    end
    e.busy = 1'b1;
    if (k <= len0) begin
      ph  = 0;
      off = k - 1;
    end else begin
      ph  = (k - len0 - 1) / lens + 1;
      off = (k - len0 - 1) % lens;
    end
    e.stage   = 4'(ph);
    e.rd_bank = 1'(ph % 2);
    niss = (ph == 0) ? n : n / 2;
    half = (ph == 0) ? 1 : (1 << (ph - 1));
    if (off < niss) begin
      e.rd_en_a = 1'b1;
      if (ph == 0) begin
        e.rd_addr_a = 4'(off);
      end else begin
        i = pair_lo(n, half, off);
        e.rd_en_b   = 1'b1;
        e.rd_addr_a = 4'(i);
        e.rd_addr_b = 4'(i + half);
        e.tw        = 4'((i % half) * (n / (2 * half)));
      end
    end
    if (off >= pl && off < niss + pl) begin
      r = off - pl;
      e.wr_en_a = 1'b1;
      if (ph == 0) begin
        e.wr_addr_a = 4'(bitrev_m(r, lg));
      end else begin
        i = pair_lo(n, half, r);
        e.wr_en_b   = 1'b1;
        e.wr_addr_a = 4'(i);
        e.wr_addr_b = 4'(i + half);
      end
    end
    return e;
  endfunction

  function automatic cyc_t obs8();
    cyc_t o;
    o = '0;
    o.busy = busy8;  o.done = done8;  o.stage = 4'(stage8);  o.rd_bank = rd_bank8;
    o.rd_en_a = rd_en_a8;  o.rd_en_b = rd_en_b8;
    o.rd_addr_a = 4'(rd_addr_a8);  o.rd_addr_b = 4'(rd_addr_b8);
    o.wr_en_a = wr_en_a8;  o.wr_en_b = wr_en_b8;
    o.wr_addr_a = 4'(wr_addr_a8);  o.wr_addr_b = 4'(wr_addr_b8);
    o.tw = 4'(tw8);  o.out_bank = out_bank8;
    return o;
  endfunction

  function automatic cyc_t obs16();
    cyc_t o;
    o = '0;
    o.busy = busy16;  o.done = done16;  o.stage = stage16;  o.rd_bank = rd_bank16;
    o.rd_en_a = rd_en_a16;  o.rd_en_b = rd_en_b16;
    o.rd_addr_a = rd_addr_a16;  o.rd_addr_b = rd_addr_b16;
    o.wr_en_a = wr_en_a16;  o.wr_en_b = wr_en_b16;
    o.wr_addr_a = wr_addr_a16;  o.wr_addr_b = wr_addr_b16;
    o.tw = 4'(tw16);  o.out_bank = out_bank16;
    return o;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start8();
    start8 = 1'b1;
    step();
    start8 = 1'b0;
  endtask

  task automatic test_reset();
    cyc_t o;
    rst = 1'b1;
    start8 = 1'b0;
    start16 = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    for (int j = 0; j < 2; j++) begin
      o = obs8();
      n_cmp++;
      if (o !== '0) begin
        n_bad++;
        $display("FAIL reset8 j=%0d got=%h want=%h", j, o, 32'h0);
      end
      o = obs16();
      n_cmp++;
      if (o !== '0) begin
        n_bad++;
        $display("FAIL reset16 j=%0d got=%h want=%h", j, o, 32'h0);
      end
      step();
    end
  endtask

  task automatic test_transform8();
    cyc_t o, e;
    int gap;
    gap = $urandom_range(0, 4);
    repeat (gap) step();
    pulse_start8();
    for (int k = 1; k <= T8 + 2; k++) begin
      e = model(N8, L8, P8, k, 1'b0);
      o = obs8();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL transform8 k=%0d got=%h want=%h", k, o, e);
      end
      step();
    end
  endtask

  task automatic test_write_coverage();
    cyc_t o, e;
    int wc [5][16];
    for (int p = 0; p < 5; p++)
      for (int a = 0; a < 16; a++) wc[p][a] = 0;
    pulse_start8();
    for (int k = 1; k <= T8; k++) begin
      e = model(N8, L8, P8, k, 1'b0);
      o = obs8();
      if (o.wr_en_a === 1'b1) wc[int'(e.stage)][int'(o.wr_addr_a)]++;
      if (o.wr_en_b === 1'b1) wc[int'(e.stage)][int'(o.wr_addr_b)]++;
      step();
    end
    for (int p = 0; p <= L8; p++) begin
      for (int a = 0; a < N8; a++) begin
        n_cmp++;
        if (wc[p][a] != 1) begin
          n_bad++;
          $display("FAIL wrcover phase=%0d addr=%0d got=%0d want=1", p, a, wc[p][a]);
        end
      end
    end
  endtask

  task automatic test_start_ignored();
    cyc_t o, e;
    pulse_start8();
    for (int k = 1; k <= T8 + 2; k++) begin
      e = model(N8, L8, P8, k, 1'b0);
      o = obs8();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL start_ignored k=%0d got=%h want=%h", k, o, e);
      end
      start8 = (k >= 1 && k <= T8 - 2 && $urandom_range(0, 2) == 0);
      step();
    end
    start8 = 1'b0;
  endtask

  task automatic test_back_to_back();
    cyc_t o, e;
    int kk;
    start8 = 1'b1;
    step();
    for (int k = 1; k <= 2 * (T8 + 1) + 2; k++) begin
      kk = (k - 1) % (T8 + 1) + 1;
      if (k > 2 * (T8 + 1)) kk = T8 + 1;
      e = model(N8, L8, P8, kk, 1'b0);
      o = obs8();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL back_to_back k=%0d got=%h want=%h", k, o, e);
      end
      if (k == T8 + 2) start8 = 1'b0;
      step();
    end
  endtask

  task automatic test_reset_mid();
    cyc_t o, e;
    int ab;
    for (int rep = 0; rep < 3; rep++) begin
      ab = (rep == 0) ? (N8 + P8 + 1) + 5 : $urandom_range(2, T8 - 1);
      pulse_start8();
      for (int k = 1; k <= ab; k++) begin
        e = model(N8, L8, P8, k, 1'b0);
        o = obs8();
        n_cmp++;
        if (o !== e) begin
          n_bad++;
          $display("FAIL pre_abort rep=%0d k=%0d got=%h want=%h", rep, k, o, e);
        end
        if (k < ab) step();
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int j = 0; j < 3; j++) begin
        o = obs8();
        n_cmp++;
        if (o !== '0) begin
          n_bad++;
          $display("FAIL abort rep=%0d j=%0d got=%h want=%h", rep, j, o, 32'h0);
        end
        step();
      end
    end
    pulse_start8();
    for (int k = 1; k <= T8 + 1; k++) begin
      e = model(N8, L8, P8, k, 1'b0);
      o = obs8();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL restart k=%0d got=%h want=%h", k, o, e);
      end
      step();
    end
  endtask

  task automatic test_n16(input logic ob_prev);
    cyc_t o, e;
    start16 = 1'b1;
    step();
    start16 = 1'b0;
    for (int k = 1; k <= T16 + 2; k++) begin
      e = model(N16, L16, P16, k, ob_prev);
      o = obs16();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL n16 k=%0d got=%h want=%h", k, o, e);
      end
      step();
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    start8 = 1'b0;
    start16 = 1'b0;
    test_reset();
    test_transform8();
    test_write_coverage();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    test_n16(1'b0);
    test_n16(1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
